scramble_move_generator: RTL and testbench

- Sits directly downstream of the shuffle/solve state block and consumes its random-request level output.
- On a request, emits a burst of NUM_MOVES pseudo-random tile-move directions to the puzzle board logic over a valid/ready handshake, then pulses done.
- A free-running LFSR supplies the randomness, so the move sequence depends on how many cycles pass before the player presses scramble.
- Never emits a move that directly undoes the previous one.

---
 rtl/scramble_move_generator.sv | 134 +++++++++++++
 tb/tb_scramble_move_generator.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/scramble_move_generator.sv
// Scramble burst generator: on a rising scramble request, issues NUM_MOVES
// pseudo-random tile moves over valid/ready, never undoing the previous move.
module scramble_move_generator #(
    parameter int unsigned NUM_MOVES = 31,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             random_please,
    input  logic             abort,
    input  logic             move_ready,
    output logic             move_valid,
    output logic [1:0]       move_dir,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] moves_left
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [15:0]      LFSR_MASK   = 16'hB400;
    localparam logic [CNT_W-1:0] NUM_MOVES_C = CNT_W'(NUM_MOVES);
    localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);

    state_t           state_q, state_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic             req_q, req_d;
    logic [1:0]       move_dir_q, move_dir_d;
    logic [1:0]       prev_dir_q, prev_dir_d;
    logic             prev_valid_q, prev_valid_d;
    logic [CNT_W-1:0] moves_left_q, moves_left_d;

    logic       start;
    logic       handshake;
    logic       last_move;
    logic [1:0] cand;

    // Replace the exact undo of the previous move (up<->down, left<->right)
    // with one of the perpendicular directions.
    function automatic logic [1:0] undo_filter(input logic [1:0] c,
                                               input logic [1:0] prev,
                                               input logic       prev_ok);
        return (prev_ok && (c == (prev ^ 2'b01))) ? (c ^ 2'b10) : c;
    endfunction

    assign start     = random_please & ~req_q;
    assign cand      = lfsr_q[1:0];
    assign handshake = (state_q == ISSUE) & move_ready & ~abort;
    assign last_move = (moves_left_q == ONE);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values computed by the comb blocks.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            lfsr_q       <= LFSR_SEED;
            req_q        <= 1'b0;
            move_dir_q   <= 2'b00;
            prev_dir_q   <= 2'b00;
            prev_valid_q <= 1'b0;
            moves_left_q <= '0;
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            req_q        <= req_d;
            move_dir_q   <= move_dir_d;
            prev_dir_q   <= prev_dir_d;
            prev_valid_q <= prev_valid_d;
            moves_left_q <= moves_left_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = ISSUE;
            ISSUE: begin
                if (abort)                       state_d = IDLE;
                else if (move_ready && last_move) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: every signal assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        lfsr_d       = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);
        req_d        = random_please;
        move_dir_d   = move_dir_q;
        prev_dir_d   = prev_dir_q;
        prev_valid_d = prev_valid_q;
        moves_left_d = moves_left_q;

        unique case (state_q)
            IDLE: begin
                // First move of a burst is never filtered.
                if (start) begin
                    moves_left_d = NUM_MOVES_C;
                    move_dir_d   = cand;
                    prev_valid_d = 1'b0;
                end
            end
            ISSUE: begin
                if (abort) begin
                    moves_left_d = '0;
                end else if (handshake) begin
                    prev_dir_d   = move_dir_q;
                    prev_valid_d = 1'b1;
                    moves_left_d = moves_left_q - ONE;
                    // The next move is filtered against the one just accepted.
                    if (!last_move) move_dir_d = undo_filter(cand, prev_dir_d, prev_valid_d);
                end
            end
            DONE:    moves_left_d = '0;
            default: moves_left_d = '0;
        endcase
    end

    always_comb begin
        move_valid = (state_q == ISSUE);
        busy       = (state_q == ISSUE);
        done       = (state_q == DONE);
        move_dir   = move_dir_q;
        moves_left = moves_left_q;
    end

endmodule

// File: tb/tb_scramble_move_generator.sv
// Bench for scramble_move_generator: a behavioural model pushes each expected
// move to a queue, and the queue is popped as the DUT presents new moves.
module tb_scramble_move_generator;

    localparam int          NUM_MOVES = 31;
    localparam logic [15:0] SEED      = 16'hACE1;
    localparam int          S_IDLE    = 0;
    localparam int          S_ISSUE   = 1;
    localparam int          S_DONE    = 2;

    logic       clk;
    logic       rst_n;
    logic       random_please;
    logic       abort;
    logic       move_ready;
    logic       move_valid;
    logic [1:0] move_dir;
    logic       busy;
    logic       done;
    logic [7:0] moves_left;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [15:0] m_lfsr  = SEED;
    int          m_state = S_IDLE;
    int          m_left  = 0;
    logic [1:0]  m_dir   = 2'b00;
    logic        m_req   = 1'b0;
    logic [1:0]  exp_q[$];

    scramble_move_generator #(
        .NUM_MOVES(NUM_MOVES),
        .LFSR_SEED(SEED),
        .CNT_W    (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .random_please(random_please),
        .abort        (abort),
        .move_ready   (move_ready),
        .move_valid   (move_valid),
        .move_dir     (move_dir),
        .busy         (busy),
        .done         (done),
        .moves_left   (moves_left)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance the model on the current inputs, clock the DUT once, then compare.
    task automatic step();
        logic       st;
        logic [1:0] cand;
        logic [1:0] exp_dir;
        bit         new_move = 1'b0;
        if (!rst_n) begin
            m_lfsr  = SEED;
            m_state = S_IDLE;
            m_left  = 0;
            m_dir   = 2'b00;
            m_req   = 1'b0;
            exp_q.delete();
        end else begin
            st   = random_please & ~m_req;
            cand = m_lfsr[1:0];
            if (m_state == S_IDLE) begin
                if (st) begin
                    m_state  = S_ISSUE;
                    m_left   = NUM_MOVES;
                    m_dir    = cand;
                    new_move = 1'b1;
                end
            end else if (m_state == S_ISSUE) begin
                if (abort) begin
                    m_state = S_IDLE;
                    m_left  = 0;
                end else if (move_ready) begin
                    m_left = m_left - 1;
                    if (m_left == 0) begin
                        m_state = S_DONE;
                    end else begin
                        m_dir    = (cand == (m_dir ^ 2'b01)) ? (cand ^ 2'b10) : cand;
                        new_move = 1'b1;
                    end
                end
            end else begin
                m_state = S_IDLE;
            end
            m_req  = random_please;
            m_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
        end
        if (new_move) exp_q.push_back(m_dir);

        @(posedge clk);
        #1;
        check("move_valid", 32'(move_valid), 32'(m_state == S_ISSUE));
        check("busy", 32'(busy), 32'(m_state == S_ISSUE));
        check("done", 32'(done), 32'(m_state == S_DONE));
        check("moves_left", 32'(moves_left), 32'(m_left));
        if (new_move && exp_q.size() > 0) begin
            exp_dir = exp_q.pop_front();
            check("move_dir", 32'(move_dir), 32'(exp_dir));
        end else if (m_state == S_ISSUE) begin
            check("move_dir_hold", 32'(move_dir), 32'(m_dir));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // ready_mode: 0 = always ready, 1 = pattern 1,0,0 repeating, 2 = random.
    // rereq_at / abort_at / rst_at: handshake count at which to act (-1 = never).
    task automatic run_burst(input int ready_mode, input int rereq_at, input int abort_at,
                             input int rst_at, input int exp_hs, input int exp_done,
                             input int exp_valid);
        int         hs        = 0;
        int         dn        = 0;
        int         vc        = 0;
        bit         have_last = 1'b0;
        bit         finished  = 1'b0;
        logic [1:0] last      = 2'b00;
        for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
            random_please = (cyc < 5) || (rereq_at >= 0 && (hs == rereq_at || hs == rereq_at + 1));
            if (ready_mode == 0)      move_ready = 1'b1;
            else if (ready_mode == 1) move_ready = (cyc % 3 == 0);
            else                      move_ready = 1'($urandom_range(0, 1));
            abort = (abort_at >= 0) && (hs == abort_at) && move_valid;
            rst_n = !((rst_at >= 0) && (hs == rst_at) && move_valid);

            if (move_valid && move_ready && !abort && rst_n) begin
                if (have_last) check("no_undo", 32'((move_dir ^ last) == 2'b01), 32'd0);
                last      = move_dir;
                have_last = 1'b1;
                hs++;
            end

            step();
            if (!rst_n) check("lfsr_reseed", 32'(dut.lfsr_q), 32'(SEED));
            if (move_valid) vc++;
            if (done) dn++;
            if (cyc > 0 && !busy && !done) finished = 1'b1;
        end
        if (!finished) check("burst_timeout", 32'd0, 32'd1);
        random_please = 1'b0;
        abort         = 1'b0;
        rst_n         = 1'b1;
        move_ready    = 1'b0;
        check("handshakes", 32'(hs), 32'(exp_hs));
        check("done_pulses", 32'(dn), 32'(exp_done));
        if (exp_valid >= 0) check("valid_cycles", 32'(vc), 32'(exp_valid));
    endtask

    initial begin
        int quiet;
        rst_n         = 1'b0;
        random_please = 1'b0;
        abort         = 1'b0;
        move_ready    = 1'b0;

        idle(3);
        rst_n = 1'b1;
        check("lfsr_seed", 32'(dut.lfsr_q), 32'(SEED));

        // Full burst, no backpressure
        run_burst(0, -1, -1, -1, NUM_MOVES, 1, NUM_MOVES);
        idle(3);

        // Backpressure 1,0,0 pattern
        run_burst(1, -1, -1, -1, NUM_MOVES, 1, -1);
        idle(2);

        // Re-request mid-burst is ignored, and no second burst follows
        run_burst(0, 10, -1, -1, NUM_MOVES, 1, NUM_MOVES);
        quiet = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (move_valid || busy) quiet++;
        end
        check("no_second_burst", 32'(quiet), 32'd0);

        // Abort at handshake 12, then a full burst
        run_burst(0, -1, 12, -1, 12, 0, -1);
        idle(2);
        run_burst(0, -1, -1, -1, NUM_MOVES, 1, NUM_MOVES);
        idle(2);

        // Reset at handshake 5, then a full burst
        run_burst(0, -1, -1, 5, 5, 0, -1);
        idle(1);
        run_burst(0, -1, -1, -1, NUM_MOVES, 1, NUM_MOVES);

        // Many bursts after random delays with mixed backpressure
        for (int b = 0; b < 100; b++) begin
            idle(int'($urandom_range(0, 40)));
            run_burst(int'($urandom_range(0, 2)), -1, -1, -1, NUM_MOVES, 1, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
